// File: rtl/clk_gate_ctrl_pkg.sv
// clk_gate_ctrl_pkg
//   Shared types for the clock-gate controller.
//   clk_gate_state_e : controller state (RUN, GATED, WAKE).
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,  // downstream clock running, idle counter active
    GATED = 2'd1,  // downstream clock stopped
    WAKE  = 2'd2   // clock re-enabled, waiting for it to settle
  } clk_gate_state_e;

endpackage : clk_gate_ctrl_pkg

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl
//   Idle-detecting controller driving the en_i input of the tc_clk_gating
//   cell that guards one downstream clock domain. Lives in the free-running
//   clock domain. Counts consecutive idle cycles of the consumer, stops the
//   downstream clock after a programmable threshold, restarts it on demand
//   and holds off upstream grants until the clock has settled.
//
// Ports
//   clk_i              free-running (ungated) clock
//   rst_i              synchronous, active-high reset
//   cfg_en_i           auto-gating enable (0 keeps the clock running)
//   cfg_idle_thresh_i  idle cycles before gating (0 = never gate)
//   test_mode_i        DFT mode: inhibits gating and forces wake
//   busy_i             downstream consumer busy
//   req_i              upstream request, held until granted
//   gnt_o              request accepted this cycle
//   clk_en_o           to tc_clk_gating.en_i, straight from a flop
//   gated_o            status: controller is in GATED
//   wake_cnt_o         saturating count of GATED->WAKE transitions
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned CntWidth  = 8,
  parameter int unsigned WakeDelay = 2,
  parameter int unsigned StatWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_en_i,
  input  logic [CntWidth-1:0]  cfg_idle_thresh_i,
  input  logic                 test_mode_i,
  input  logic                 busy_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  output logic                 clk_en_o,
  output logic                 gated_o,
  output logic [StatWidth-1:0] wake_cnt_o
);

  // Settle counter only has to hold WakeDelay-1.
  localparam int unsigned SettleWidth = (WakeDelay > 1) ? $clog2(WakeDelay) : 1;
  localparam logic [SettleWidth-1:0] SettleLoad = SettleWidth'(WakeDelay - 1);

  clk_gate_state_e        state_q, state_d;
  logic [CntWidth-1:0]    idle_cnt_q, idle_cnt_d;
  logic [SettleWidth-1:0] settle_q, settle_d;
  logic [StatWidth-1:0]   wake_cnt_q, wake_cnt_d;

  // Dedicated enable flop: the gate input must never see decode glitches,
  // so it is kept separate from the state register.
  (* keep = "true" *) logic clk_en_q;

  logic              idle;
  logic              inhibit;
  logic [CntWidth:0] cnt_inc;
  logic              thresh_met;

  assign idle    = !busy_i && !req_i;
  assign inhibit = !cfg_en_i || test_mode_i || (cfg_idle_thresh_i == '0);

  // One extra bit so the threshold compare is exact even at cnt = all-ones.
  assign cnt_inc    = {1'b0, idle_cnt_q} + (CntWidth + 1)'(1);
  assign thresh_met = cnt_inc >= {1'b0, cfg_idle_thresh_i};

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    settle_d   = settle_q;
    wake_cnt_d = wake_cnt_q;

    unique case (state_q)
      RUN: begin
        if (idle && !inhibit) begin
          if (thresh_met) begin
            state_d    = GATED;
            idle_cnt_d = '0;
          end else if (!(&idle_cnt_q)) begin
            idle_cnt_d = idle_cnt_q + CntWidth'(1);
          end
        end else begin
          // Any activity or inhibit restarts the idle run.
          idle_cnt_d = '0;
        end
      end

      GATED: begin
        if (req_i || busy_i || inhibit) begin
          state_d  = WAKE;
          settle_d = SettleLoad;
          if (!(&wake_cnt_q)) begin
            wake_cnt_d = wake_cnt_q + StatWidth'(1);
          end
        end
      end

      WAKE: begin
        // Inputs are deliberately ignored until the clock has settled.
        if (settle_q == '0) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q - SettleWidth'(1);
        end
      end

      default: begin
        state_d    = RUN;
        idle_cnt_d = '0;
        settle_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      idle_cnt_q <= '0;
      settle_q   <= '0;
      wake_cnt_q <= '0;
      // Clock stays enabled in reset so downstream resets propagate.
      clk_en_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      settle_q   <= settle_d;
      wake_cnt_q <= wake_cnt_d;
      clk_en_q   <= (state_d != GATED);
    end
  end

  assign gnt_o      = (state_q == RUN) && req_i;
  assign clk_en_o   = clk_en_q;
  assign gated_o    = (state_q == GATED);
  assign wake_cnt_o = wake_cnt_q;

endmodule : clk_gate_ctrl

// File: tb/tb_clk_gate_ctrl.sv
// tb_clk_gate_ctrl
//   Directed bench for clk_gate_ctrl. A table of per-cycle vectors with
//   hand-computed outputs covers the main FSM paths; hand-written sequences
//   cover gating latency, wake latency, inhibits, reset and saturation.
//   A second instance with StatWidth=4 shares the stimulus.
module tb_clk_gate_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic [7:0]  cfg_idle_thresh_i;
  logic        test_mode_i;
  logic        busy_i;
  logic        req_i;
  logic        gnt_o, clk_en_o, gated_o;
  logic [15:0] wake_cnt_o;
  logic        gnt_s, clk_en_s, gated_s;
  logic [3:0]  wake_cnt_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  clk_gate_ctrl #(.CntWidth(8), .WakeDelay(2), .StatWidth(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i),
    .cfg_idle_thresh_i(cfg_idle_thresh_i), .test_mode_i(test_mode_i),
    .busy_i(busy_i), .req_i(req_i), .gnt_o(gnt_o), .clk_en_o(clk_en_o),
    .gated_o(gated_o), .wake_cnt_o(wake_cnt_o)
  );

  clk_gate_ctrl #(.CntWidth(8), .WakeDelay(2), .StatWidth(4)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i),
    .cfg_idle_thresh_i(cfg_idle_thresh_i), .test_mode_i(test_mode_i),
    .busy_i(busy_i), .req_i(req_i), .gnt_o(gnt_s), .clk_en_o(clk_en_s),
    .gated_o(gated_s), .wake_cnt_o(wake_cnt_s)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [7:0]  th;
    logic        tm;
    logic        busy;
    logic        req;
    logic        e_gnt;
    logic        e_clk_en;
    logic        e_gated;
    logic [15:0] e_wake;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic en, logic [7:0] th, logic tm,
                              logic busy, logic req, logic e_gnt,
                              logic e_clk_en, logic e_gated, logic [15:0] e_wake);
    vec_t v;
    v.rst = rst; v.en = en; v.th = th; v.tm = tm; v.busy = busy; v.req = req;
    v.e_gnt = e_gnt; v.e_clk_en = e_clk_en; v.e_gated = e_gated; v.e_wake = e_wake;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled at the next one.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_in(logic rst, logic en, logic [7:0] th, logic tm,
                        logic busy, logic req);
    rst_i = rst; cfg_en_i = en; cfg_idle_thresh_i = th;
    test_mode_i = tm; busy_i = busy; req_i = req;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_i = 1'b0;
  endtask

  // Ticks idle cycles until clk_en_o drops; returns the count (or limit).
  task automatic count_to_gate(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (clk_en_o == 1'b1 && n < limit);
  endtask

  initial begin
    int n;
    logic dropped;

    set_in(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);

    //        rst en th  tm bz rq   gnt ce gt wake
    tbl.push_back(mk(1, 1, 3, 0, 0, 0,  0, 1, 0, 0)); // reset
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 1, 0, 0)); // cnt 1
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 1, 0, 0)); // cnt 2
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 0, 1, 0)); // 3rd idle -> GATED
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 0, 1, 0)); // stays GATED
    tbl.push_back(mk(0, 1, 3, 0, 0, 1,  0, 1, 0, 1)); // req -> WAKE
    tbl.push_back(mk(0, 1, 3, 0, 0, 1,  0, 1, 0, 1)); // settling
    tbl.push_back(mk(0, 1, 3, 0, 0, 1,  1, 1, 0, 1)); // RUN, granted
    tbl.push_back(mk(0, 1, 3, 0, 1, 0,  0, 1, 0, 1)); // busy
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 1, 0, 1)); // cnt 1
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 1, 0, 1)); // cnt 2
    tbl.push_back(mk(0, 1, 3, 0, 1, 0,  0, 1, 0, 1)); // busy at threshold
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 1, 0, 1)); // cnt 1
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 1, 0, 1)); // cnt 2
    tbl.push_back(mk(0, 1, 3, 0, 0, 0,  0, 0, 1, 1)); // GATED
    tbl.push_back(mk(0, 1, 3, 1, 0, 0,  0, 1, 0, 2)); // test_mode -> WAKE
    tbl.push_back(mk(0, 1, 3, 1, 0, 0,  0, 1, 0, 2)); // settling
    tbl.push_back(mk(0, 1, 3, 1, 0, 0,  0, 1, 0, 2)); // RUN
    tbl.push_back(mk(0, 1, 3, 1, 0, 0,  0, 1, 0, 2)); // inhibited idle
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 1, 0, 2)); // cnt 1
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 1, 0, 2)); // cnt 2
    tbl.push_back(mk(0, 1, 10, 0, 0, 0, 0, 1, 0, 2)); // cnt 3
    tbl.push_back(mk(0, 1, 2, 0, 0, 0,  0, 0, 1, 2)); // thresh lowered -> GATED
    tbl.push_back(mk(0, 1, 2, 0, 1, 0,  0, 1, 0, 3)); // busy -> WAKE
    tbl.push_back(mk(0, 1, 2, 0, 1, 0,  0, 1, 0, 3)); // WAKE ignores inputs
    tbl.push_back(mk(0, 1, 2, 0, 0, 0,  0, 1, 0, 3)); // RUN
    tbl.push_back(mk(0, 1, 2, 0, 0, 1,  1, 1, 0, 3)); // req in RUN
    tbl.push_back(mk(0, 0, 2, 0, 0, 0,  0, 1, 0, 3)); // cfg_en=0

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].rst, tbl[i].en, tbl[i].th, tbl[i].tm, tbl[i].busy, tbl[i].req);
      tick();
      check($sformatf("vec%0d gnt", i), 32'(gnt_o), 32'(tbl[i].e_gnt));
      check($sformatf("vec%0d clk_en", i), 32'(clk_en_o), 32'(tbl[i].e_clk_en));
      check($sformatf("vec%0d gated", i), 32'(gated_o), 32'(tbl[i].e_gated));
      check($sformatf("vec%0d wake_cnt", i), 32'(wake_cnt_o), 32'(tbl[i].e_wake));
    end

    // Idle gating latency with thresh=16, then wake by request.
    do_reset();
    set_in(1'b0, 1'b1, 8'd16, 1'b0, 1'b0, 1'b0);
    count_to_gate(100, n);
    check("gate_latency_16", 32'(n), 32'd16);
    check("gated_after_16", 32'(gated_o), 32'd1);
    req_i = 1'b1;
    tick();
    check("wake_clk_en_t1", 32'(clk_en_o), 32'd1);
    check("wake_gnt_t1", 32'(gnt_o), 32'd0);
    tick();
    check("wake_gnt_t2", 32'(gnt_o), 32'd0);
    tick();
    check("wake_gnt_t3", 32'(gnt_o), 32'd1);
    check("wake_cnt_1", 32'(wake_cnt_o), 32'd1);
    req_i = 1'b0;

    // Inhibits: thresh=0, cfg_en=0, test_mode=1, each for 1000 idle cycles.
    do_reset();
    dropped = 1'b0;
    set_in(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin tick(); if (!clk_en_o) dropped = 1'b1; end
    check("inhibit_thresh0", 32'(dropped), 32'd0);
    dropped = 1'b0;
    set_in(1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin tick(); if (!clk_en_o) dropped = 1'b1; end
    check("inhibit_cfg_en0", 32'(dropped), 32'd0);
    dropped = 1'b0;
    set_in(1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin tick(); if (!clk_en_o) dropped = 1'b1; end
    check("inhibit_test_mode", 32'(dropped), 32'd0);
    test_mode_i = 1'b0;
    count_to_gate(100, n);
    check("gate_latency_5", 32'(n), 32'd5);
    test_mode_i = 1'b1;
    tick();
    check("tm_wake_clk_en", 32'(clk_en_o), 32'd1);
    check("tm_wake_gated", 32'(gated_o), 32'd0);
    tick();
    tick();
    req_i = 1'b1;
    #1;
    check("tm_back_to_run", 32'(gnt_o), 32'd1);
    req_i = 1'b0;
    test_mode_i = 1'b0;

    // Reset while GATED.
    do_reset();
    set_in(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    busy_i = 1'b1; tick();
    busy_i = 1'b0; tick(); tick();
    tick(); tick();
    check("pre_rst_gated", 32'(gated_o), 32'd1);
    check("pre_rst_wake_cnt", 32'(wake_cnt_o), 32'd1);
    rst_i = 1'b1;
    tick();
    check("rst_gated_clk_en", 32'(clk_en_o), 32'd1);
    check("rst_gated_gated", 32'(gated_o), 32'd0);
    check("rst_gated_wake_cnt", 32'(wake_cnt_o), 32'd0);
    rst_i = 1'b0;
    req_i = 1'b1;
    #1;
    check("rst_gated_run", 32'(gnt_o), 32'd1);
    req_i = 1'b0;

    // Reset while WAKE.
    tick(); tick();
    busy_i = 1'b1;
    tick();
    check("pre_rst_wake_state", 32'(clk_en_o & ~gated_o), 32'd1);
    check("pre_rst_wake_cnt2", 32'(wake_cnt_o), 32'd1);
    rst_i = 1'b1;
    busy_i = 1'b0;
    tick();
    check("rst_wake_clk_en", 32'(clk_en_o), 32'd1);
    check("rst_wake_wake_cnt", 32'(wake_cnt_o), 32'd0);
    rst_i = 1'b0;
    req_i = 1'b1;
    #1;
    check("rst_wake_run", 32'(gnt_o), 32'd1);
    req_i = 1'b0;

    // Wake counter saturation: 20 gate/wake rounds.
    do_reset();
    set_in(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      busy_i = 1'b0; tick();
      busy_i = 1'b1; tick();
      busy_i = 1'b0; tick(); tick();
      check($sformatf("sat_round%0d", i), 32'(wake_cnt_s), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    check("wake_cnt_20", 32'(wake_cnt_o), 32'd20);
    check("wake_cnt_sat_15", 32'(wake_cnt_s), 32'd15);

    // Maximum threshold: no wrap of the idle counter.
    do_reset();
    set_in(1'b0, 1'b1, 8'd255, 1'b0, 1'b0, 1'b0);
    count_to_gate(400, n);
    check("gate_latency_255", 32'(n), 32'd255);
    check("gated_after_255", 32'(gated_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clk_gate_ctrl
